decode_queue: RTL and testbench

- Parametrised in-order FIFO between the decoder and dispatch. Buffers packed decoded-instruction packets.
- Generalises the fixed 2-in/2-out decode buffer:
  - configurable data width, depth, enqueue ways and dequeue ways;
  - compaction of sparse valid lanes on enqueue;
  - counted partial dequeue;
  - flush;
  - sticky protocol-error reporting.

---
 rtl/decode_queue.sv | 154 +++++++++++++++
 tb/tb_decode_queue.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue: in-order FIFO between the decoder and dispatch.
// IN_WAYS lanes in, compacted on write; OUT_WAYS lanes out, counted partial pop.
// Flush, sticky pop_err, registered get_data_req.
// Optional build macro DECODE_QUEUE_STATS_EN adds full/stall cycle counters and
// an occupancy high-water mark.

// Read lane: presents one head-relative entry, zeroed when the lane is invalid.
module decode_queue_rd_lane #(
  parameter int DATA_WIDTH = 202
) (
  input  logic                  i_vld,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);
  assign o_data = i_vld ? i_data : '0;
endmodule

module decode_queue #(
  parameter int DATA_WIDTH = 202,
  parameter int DEPTH      = 16,
  parameter int IN_WAYS    = 2,
  parameter int OUT_WAYS   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [IN_WAYS-1:0]             in_valid,
  input  logic [IN_WAYS*DATA_WIDTH-1:0]  in_data,
  output logic                           in_ready,
  output logic [OUT_WAYS-1:0]            out_valid,
  output logic [OUT_WAYS*DATA_WIDTH-1:0] out_data,
  input  logic [$clog2(OUT_WAYS+1)-1:0]  pop_cnt,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty,
  output logic                           get_data_req,
  output logic                           pop_err
`ifdef DECODE_QUEUE_STATS_EN
  ,
  output logic [31:0]                    stat_full_cycles,
  output logic [31:0]                    stat_stall_cycles,
  output logic [$clog2(DEPTH+1)-1:0]     stat_high_water
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int FW = CW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_head, r_tail;
  logic [CW-1:0]         r_count;
  logic                  r_pop_err, r_gdr;

  logic [IN_WAYS-1:0][PW-1:0] w_off;
  logic [CW-1:0]  w_n_in, w_nvld, w_pop, w_n_out, w_cnt_nxt;
  logic [FW-1:0]  w_free, w_free_nxt;
  logic           w_in_ready, w_enq, w_over, w_gdr_nxt;

  // Compaction: each valid lane lands at tail + (number of valid lanes below it).
  always_comb begin
    w_n_in = '0;
    w_off  = '0;
    for (int i = 0; i < IN_WAYS; i++) begin
      w_off[i] = PW'(w_n_in);
      w_n_in   = w_n_in + CW'(in_valid[i]);
    end
  end

  // Occupancy bookkeeping: free space, clamped pop, next count.
  always_comb begin
    w_free     = FW'(DEPTH) - FW'(r_count);
    w_in_ready = (w_free >= FW'(IN_WAYS));
    w_enq      = w_in_ready && (|in_valid) && !flush;
    w_nvld     = (r_count >= CW'(OUT_WAYS)) ? CW'(OUT_WAYS) : r_count;
    w_pop      = CW'(pop_cnt);
    w_over     = (w_pop > w_nvld);
    w_n_out    = w_over ? w_nvld : w_pop;
    w_cnt_nxt  = flush ? '0 : (r_count + (w_enq ? w_n_in : '0) - w_n_out);
    w_free_nxt = FW'(DEPTH) - FW'(w_cnt_nxt);
    w_gdr_nxt  = (w_free_nxt >= FW'(2*IN_WAYS));
  end

  // Pointer, count and status state; flush outranks enqueue and dequeue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_pop_err <= 1'b0;
      r_gdr     <= 1'b1;
    end else begin
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_enq) r_tail <= r_tail + PW'(w_n_in);
        r_head  <= r_head + PW'(w_n_out);
        r_count <= w_cnt_nxt;
        if (w_over) r_pop_err <= 1'b1;
      end
      r_gdr <= w_gdr_nxt;
    end
  end

  // Storage write; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (rst && w_enq) begin
      for (int i = 0; i < IN_WAYS; i++)
        if (in_valid[i]) r_mem[r_tail + w_off[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Read lanes: lane k shows entry head+k when count > k (no write bypass).
  for (genvar k = 0; k < OUT_WAYS; k++) begin : g_rd
    logic [PW-1:0] w_idx;
    assign w_idx        = r_head + PW'(k);
    assign out_valid[k] = rst && (r_count > CW'(k));
    decode_queue_rd_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .i_vld  (out_valid[k]),
      .i_data (r_mem[w_idx]),
      .o_data (out_data[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign in_ready     = !rst || w_in_ready;
  assign count        = r_count;
  assign full         = rst && (r_count == CW'(DEPTH));
  assign empty        = !rst || (r_count == '0);
  assign get_data_req = r_gdr;
  assign pop_err      = r_pop_err;

`ifdef DECODE_QUEUE_STATS_EN
  logic [31:0]   r_full_cyc, r_stall_cyc;
  logic [CW-1:0] r_high;

  // Statistics: cleared by reset only, saturating cycle counters, max occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_full_cyc  <= '0;
      r_stall_cyc <= '0;
      r_high      <= '0;
    end else begin
      if ((r_count == CW'(DEPTH)) && (r_full_cyc != '1)) r_full_cyc <= r_full_cyc + 32'd1;
      if ((|in_valid) && !w_in_ready && (r_stall_cyc != '1)) r_stall_cyc <= r_stall_cyc + 32'd1;
      if (w_cnt_nxt > r_high) r_high <= w_cnt_nxt;
    end
  end

  assign stat_full_cycles  = r_full_cyc;
  assign stat_stall_cycles = r_stall_cyc;
  assign stat_high_water   = r_high;
`endif
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue (DEPTH=8, IN_WAYS=2, OUT_WAYS=2, DATA_WIDTH=8):
// directed vector table, wrap sequence, then random traffic against a queue model.
module tb_decode_queue;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic [1:0]  in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [15:0] out_data;
  logic [1:0]  pop_cnt;
  logic [3:0]  count;
  logic        full, empty, get_data_req, pop_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_queue #(.DATA_WIDTH(8), .DEPTH(8), .IN_WAYS(2), .OUT_WAYS(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .pop_cnt(pop_cnt),
    .count(count), .full(full), .empty(empty), .get_data_req(get_data_req), .pop_err(pop_err)
  );

  // reference model: plain queue of packets
  logic [7:0] q[$];
  bit         m_err = 0;
  bit         m_gdr = 1;

  typedef struct {
    bit r; bit fl; bit [1:0] iv; logic [7:0] d0; logic [7:0] d1; bit [1:0] pc;
    int cnt; bit [1:0] ov; logic [7:0] o0; logic [7:0] o1; bit fu; bit inr; bit gdr; bit err;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit fl, bit [1:0] iv, logic [7:0] d0, logic [7:0] d1,
                              bit [1:0] pc, int cnt, bit [1:0] ov, logic [7:0] o0,
                              logic [7:0] o1, bit fu, bit inr, bit gdr, bit err);
    vec_t v;
    v.r = r; v.fl = fl; v.iv = iv; v.d0 = d0; v.d1 = d1; v.pc = pc;
    v.cnt = cnt; v.ov = ov; v.o0 = o0; v.o1 = o1; v.fu = fu; v.inr = inr; v.gdr = gdr; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // drive one cycle, advance the model across the same edge, sample 1ns after
  task automatic apply(input bit r, input bit fl, input bit [1:0] iv,
                       input logic [7:0] d0, input logic [7:0] d1, input bit [1:0] pc);
    int nv, np;
    bit rdy;
    rst = r; flush = fl; in_valid = iv; in_data = {d1, d0}; pop_cnt = pc;
    nv  = (q.size() < 2) ? q.size() : 2;
    rdy = (8 - q.size()) >= 2;
    if (!r) begin
      q.delete(); m_err = 0; m_gdr = 1;
    end else if (fl) begin
      q.delete(); m_gdr = 1;
    end else begin
      np = (pc > nv) ? nv : pc;
      if (pc > nv) m_err = 1;
      repeat (np) void'(q.pop_front());
      if (rdy) begin
        if (iv[0]) q.push_back(d0);
        if (iv[1]) q.push_back(d1);
      end
      m_gdr = (8 - q.size()) >= 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    int c;
    c = q.size();
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".out_valid"}, 32'(out_valid), {30'd0, c > 1, c > 0});
    chk({tag, ".out_data"}, 32'(out_data), {16'd0, (c > 1) ? q[1] : 8'h00, (c > 0) ? q[0] : 8'h00});
    chk({tag, ".full"}, 32'(full), 32'(c == 8));
    chk({tag, ".empty"}, 32'(empty), 32'(c == 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'((8 - c) >= 2));
    chk({tag, ".get_data_req"}, 32'(get_data_req), 32'(m_gdr));
    chk({tag, ".pop_err"}, 32'(pop_err), 32'(m_err));
  endtask

  initial begin
    rst = 0; flush = 0; in_valid = 0; in_data = 0; pop_cnt = 0;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", 32'(count), 0);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.out_data", 32'(out_data), 0);
    chk("rst.empty", 32'(empty), 1);
    chk("rst.full", 32'(full), 0);
    chk("rst.in_ready", 32'(in_ready), 1);
    chk("rst.get_data_req", 32'(get_data_req), 1);
    chk("rst.pop_err", 32'(pop_err), 0);

    //             r fl iv     d0     d1    pc    cnt ov     o0     o1   fu inr gdr err
    tbl.push_back(mk(1,0,2'b10,8'h11,8'hA5,2'd0, 1,2'b01,8'hA5,8'h00, 0,1,1,0)); // compaction
    tbl.push_back(mk(1,0,2'b00,8'h00,8'h00,2'd1, 0,2'b00,8'h00,8'h00, 0,1,1,0));
    tbl.push_back(mk(1,0,2'b11,8'h01,8'h02,2'd0, 2,2'b11,8'h01,8'h02, 0,1,1,0)); // fill
    tbl.push_back(mk(1,0,2'b11,8'h03,8'h04,2'd0, 4,2'b11,8'h01,8'h02, 0,1,1,0));
    tbl.push_back(mk(1,0,2'b11,8'h05,8'h06,2'd0, 6,2'b11,8'h01,8'h02, 0,1,0,0));
    tbl.push_back(mk(1,0,2'b11,8'h07,8'h08,2'd0, 8,2'b11,8'h01,8'h02, 1,0,0,0));
    tbl.push_back(mk(1,0,2'b11,8'h09,8'h0A,2'd0, 8,2'b11,8'h01,8'h02, 1,0,0,0)); // ignored push
    tbl.push_back(mk(1,0,2'b00,8'h00,8'h00,2'd2, 6,2'b11,8'h03,8'h04, 0,1,0,0));
    tbl.push_back(mk(1,0,2'b00,8'h00,8'h00,2'd2, 4,2'b11,8'h05,8'h06, 0,1,1,0));
    tbl.push_back(mk(1,0,2'b00,8'h00,8'h00,2'd2, 2,2'b11,8'h07,8'h08, 0,1,1,0));
    tbl.push_back(mk(1,0,2'b00,8'h00,8'h00,2'd1, 1,2'b01,8'h08,8'h00, 0,1,1,0));
    tbl.push_back(mk(1,0,2'b00,8'h00,8'h00,2'd2, 0,2'b00,8'h00,8'h00, 0,1,1,1)); // over-pop
    tbl.push_back(mk(1,0,2'b11,8'hB0,8'hB1,2'd0, 2,2'b11,8'hB0,8'hB1, 0,1,1,1));
    tbl.push_back(mk(1,0,2'b11,8'hB2,8'hB3,2'd0, 4,2'b11,8'hB0,8'hB1, 0,1,1,1));
    tbl.push_back(mk(1,0,2'b01,8'hB4,8'hFF,2'd0, 5,2'b11,8'hB0,8'hB1, 0,1,0,1));
    tbl.push_back(mk(1,1,2'b11,8'hD0,8'hD1,2'd2, 0,2'b00,8'h00,8'h00, 0,1,1,1)); // flush wins
    tbl.push_back(mk(1,0,2'b11,8'hC0,8'hC1,2'd0, 2,2'b11,8'hC0,8'hC1, 0,1,1,1));
    tbl.push_back(mk(1,0,2'b11,8'hC2,8'hC3,2'd0, 4,2'b11,8'hC0,8'hC1, 0,1,1,1));
    tbl.push_back(mk(1,0,2'b11,8'hC4,8'hC5,2'd0, 6,2'b11,8'hC0,8'hC1, 0,1,0,1));
    tbl.push_back(mk(0,0,2'b00,8'h00,8'h00,2'd0, 0,2'b00,8'h00,8'h00, 0,1,1,0)); // reset mid-stream

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      apply(tbl[i].r, tbl[i].fl, tbl[i].iv, tbl[i].d0, tbl[i].d1, tbl[i].pc);
      chk({t, ".count"}, 32'(count), 32'(tbl[i].cnt));
      chk({t, ".out_valid"}, 32'(out_valid), 32'(tbl[i].ov));
      chk({t, ".out_data"}, 32'(out_data), {16'd0, tbl[i].o1, tbl[i].o0});
      chk({t, ".full"}, 32'(full), 32'(tbl[i].fu));
      chk({t, ".empty"}, 32'(empty), 32'(tbl[i].cnt == 0));
      chk({t, ".in_ready"}, 32'(in_ready), 32'(tbl[i].inr));
      chk({t, ".get_data_req"}, 32'(get_data_req), 32'(tbl[i].gdr));
      chk({t, ".pop_err"}, 32'(pop_err), 32'(tbl[i].err));
    end

    // wrap with concurrent ops: fill, then pop 2 / push 2 when room, sequential data
    begin
      logic [7:0] nxt;
      logic [7:0] exp_head;
      nxt = 8'h40;
      exp_head = 8'h40;
      for (int i = 0; i < 4; i++) begin
        apply(1, 0, 2'b11, nxt, nxt + 8'd1, 2'd0);
        nxt += 8'd2;
      end
      check_model("wfill");
      for (int i = 0; i < 10; i++) begin
        bit room;
        room = (8 - q.size()) >= 2;
        chk("wrap.head_seq", 32'(out_data[7:0]), 32'(exp_head));
        chk("wrap.lane1_seq", 32'(out_data[15:8]), 32'(exp_head + 8'd1));
        exp_head += 8'd2;
        apply(1, 0, room ? 2'b11 : 2'b00, nxt, nxt + 8'd1, 2'd2);
        if (room) nxt += 8'd2;
        check_model("wrap");
        chk("wrap.count_range", 32'(count >= 4'd6 && count <= 4'd8), 1);
      end
    end

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit r, fl;
      r  = ($urandom_range(0, 99) != 0);
      fl = ($urandom_range(0, 24) == 0);
      apply(r, fl, 2'($urandom), 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
